// File: rtl/alu4_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu4_input_ctrl
// Brief    : Switch/pushbutton front end for alu4; loads A, B and op, then
//            registers the ALU result with a valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu4_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic [2:0] op_sw,
    input  logic       btn_next,
    input  logic       btn_clear,
    input  logic [3:0] alu_y,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] op,
    output logic [3:0] res_y,
    output logic       res_of,
    output logic       res_zero,
    output logic       res_valid,
    output logic       err_op,
    output logic [1:0] state
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int                 c_NBTN    = 2;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        EXEC   = 2'b10,
        SHOW   = 2'b11
    } state_t;

    logic [c_NBTN-1:0] w_btn_raw;
    logic [c_NBTN-1:0] w_press;
    logic              w_next_press;
    logic              w_clear_press;

    assign w_btn_raw     = {btn_clear, btn_next};
    assign w_next_press  = w_press[0];
    assign w_clear_press = w_press[1];

    genvar gi;
    generate
        for (gi = 0; gi < c_NBTN; gi++) begin : g_btn
            logic               r_s1_q;
            logic               r_s2_q;
            logic               r_deb_q;
            logic               w_deb_d;
            logic               r_deb_dly_q;
            logic [c_CNT_W-1:0] r_cnt_q;
            logic [c_CNT_W-1:0] w_cnt_d;

            // Level must differ from the accepted one for DEBOUNCE_CYCLES edges in a row.
            always_comb begin
                w_deb_d = r_deb_q;
                w_cnt_d = '0;
                if (r_s2_q != r_deb_q) begin
                    if (r_cnt_q == c_CNT_MAX) begin
                        w_deb_d = r_s2_q;
                    end else begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1_q      <= 1'b0;
                    r_s2_q      <= 1'b0;
                    r_deb_q     <= 1'b0;
                    r_deb_dly_q <= 1'b0;
                    r_cnt_q     <= '0;
                end else begin
                    r_s1_q      <= w_btn_raw[gi];
                    r_s2_q      <= r_s1_q;
                    r_deb_q     <= w_deb_d;
                    r_deb_dly_q <= r_deb_q;
                    r_cnt_q     <= w_cnt_d;
                end
            end

            assign w_press[gi] = r_deb_q & ~r_deb_dly_q;
        end
    endgenerate

    state_t     r_state_q, w_state_d;
    logic [3:0] r_a_q, w_a_d;
    logic [3:0] r_b_q, w_b_d;
    logic [2:0] r_op_q, w_op_d;
    logic [3:0] r_res_y_q, w_res_y_d;
    logic       r_res_of_q, w_res_of_d;
    logic       r_res_zero_q, w_res_zero_d;
    logic       r_res_valid_q, w_res_valid_d;
    logic       r_err_op_q, w_err_op_d;

    always_comb begin
        w_state_d     = r_state_q;
        w_a_d         = r_a_q;
        w_b_d         = r_b_q;
        w_op_d        = r_op_q;
        w_res_y_d     = r_res_y_q;
        w_res_of_d    = r_res_of_q;
        w_res_zero_d  = r_res_zero_q;
        w_res_valid_d = r_res_valid_q;
        w_err_op_d    = r_err_op_q;
        if (w_clear_press) begin
            w_state_d     = LOAD_A;
            w_a_d         = '0;
            w_b_d         = '0;
            w_op_d        = '0;
            w_res_y_d     = '0;
            w_res_of_d    = 1'b0;
            w_res_zero_d  = 1'b0;
            w_res_valid_d = 1'b0;
            w_err_op_d    = 1'b0;
        end else begin
            case (r_state_q)
                LOAD_A: begin
                    if (w_next_press) begin
                        w_a_d     = sw;
                        w_state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (w_next_press) begin
                        if (op_sw <= 3'b100) begin
                            w_b_d      = sw;
                            w_op_d     = op_sw;
                            w_err_op_d = 1'b0;
                            w_state_d  = EXEC;
                        end else begin
                            w_err_op_d = 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for a full cycle here.
                    w_res_y_d     = alu_y;
                    w_res_of_d    = alu_overflow;
                    w_res_zero_d  = alu_zero;
                    w_res_valid_d = 1'b1;
                    w_state_d     = SHOW;
                end
                SHOW: begin
                    if (w_next_press) begin
                        w_res_valid_d = 1'b0;
                        w_state_d     = LOAD_A;
                    end
                end
                default: w_state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= LOAD_A;
            r_a_q         <= '0;
            r_b_q         <= '0;
            r_op_q        <= '0;
            r_res_y_q     <= '0;
            r_res_of_q    <= 1'b0;
            r_res_zero_q  <= 1'b0;
            r_res_valid_q <= 1'b0;
            r_err_op_q    <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_a_q         <= w_a_d;
            r_b_q         <= w_b_d;
            r_op_q        <= w_op_d;
            r_res_y_q     <= w_res_y_d;
            r_res_of_q    <= w_res_of_d;
            r_res_zero_q  <= w_res_zero_d;
            r_res_valid_q <= w_res_valid_d;
            r_err_op_q    <= w_err_op_d;
        end
    end

    assign a         = r_a_q;
    assign b         = r_b_q;
    assign op        = r_op_q;
    assign res_y     = r_res_y_q;
    assign res_of    = r_res_of_q;
    assign res_zero  = r_res_zero_q;
    assign res_valid = r_res_valid_q;
    assign err_op    = r_err_op_q;
    assign state     = r_state_q;

endmodule
`default_nettype wire
